// File: rtl/ctrl_pkg.sv
// Shared types and constants for the vector-core pipeline sequencing controller.
package ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [5:0] RTYPE = 6'b101010;
   localparam logic [5:0] VLD   = 6'b100000;
   localparam logic [5:0] VSD   = 6'b100001;
   localparam logic [5:0] VBEZ  = 6'b100010;
   localparam logic [5:0] VBNEZ = 6'b100011;
   localparam logic [5:0] VNOP  = 6'b111100;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      EX_LOAD_ID,
      EX_LOAD_NOP,
      EX_HOLD
   } ex_sel_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  wr;
      logic                  mem;
      logic                  memwr;
   } ex_shadow_t;

endpackage

// File: rtl/raw_detect.sv
// Compares the ID-stage source registers against one shadow destination entry.
module raw_detect
   import ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src_a,
   input  logic [REG_ADDR_W-1:0] src_b,
   input  logic [REG_ADDR_W-1:0] src_d,
   input  logic                  use_ab,
   input  logic                  use_d,
   input  logic [REG_ADDR_W-1:0] sh_rd,
   input  logic                  sh_wr,
   output logic                  hit
);

   assign hit = sh_wr & ((use_ab & ((src_a == sh_rd) | (src_b == sh_rd))) |
                         (use_d & (src_d == sh_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush and data-memory handshake sequencing for the 4-stage vector core.
// Build option WB_BYPASS_EN: register file writes through, so only EX-shadow matches stall.
//
// state    | meaning
// RUN      | pipeline flowing; RAW stalls and branch flushes evaluated
// MEM_WAIT | data access outstanding; front end frozen, watchdog counting
module pipe_hazard_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] ID_rD,
   input  logic [REG_ADDR_W-1:0] ID_rA,
   input  logic [REG_ADDR_W-1:0] ID_rB,
   input  logic                  ID_wrEn,
   input  logic                  ID_memEn,
   input  logic                  ID_memwrEn,
   input  logic                  ID_bez,
   input  logic                  ID_bnez,
   input  logic                  ID_rD_zero,
   input  logic                  dmem_ack,
   output logic                  PC_stall,
   output logic                  ID_stall,
   output logic                  EX_bubble,
   output logic                  EX_stall,
   output logic                  WB_bubble,
   output logic                  IF_flush,
   output logic                  dmem_req,
   output logic                  dmem_wr,
   output logic                  mem_err
);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   ex_shadow_t            ex_sh, id_sh;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_wr;
   logic                  req_wr_q, req_wr_nxt;
   ex_sel_t               ex_sel;
   logic                  wb_adv;
   logic                  id_reads_ab, id_reads_d, taken;
   logic                  ex_hit, wb_hit, raw_hit, timeout;

   assign id_reads_ab = ID_wrEn;
   assign id_reads_d  = (ID_memEn & ID_memwrEn) | ID_bez | ID_bnez;
   assign taken       = (ID_bez & ID_rD_zero) | (ID_bnez & ~ID_rD_zero);
   assign timeout     = (cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      id_sh.rd    = ID_rD;
      id_sh.wr    = ID_wrEn | (ID_memEn & ~ID_memwrEn);
      id_sh.mem   = ID_memEn;
      id_sh.memwr = ID_memEn & ID_memwrEn;
   end

   raw_detect u_raw_ex (
      .src_a (ID_rA), .src_b (ID_rB), .src_d (ID_rD),
      .use_ab(id_reads_ab), .use_d(id_reads_d),
      .sh_rd (ex_sh.rd), .sh_wr(ex_sh.wr), .hit(ex_hit)
   );

   raw_detect u_raw_wb (
      .src_a (ID_rA), .src_b (ID_rB), .src_d (ID_rD),
      .use_ab(id_reads_ab), .use_d(id_reads_d),
      .sh_rd (wb_rd), .sh_wr(wb_wr), .hit(wb_hit)
   );

`ifdef WB_BYPASS_EN
   assign raw_hit = ex_hit;
`else
   assign raw_hit = ex_hit | wb_hit;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         cnt      <= '0;
         ex_sh    <= '0;
         wb_rd    <= '0;
         wb_wr    <= 1'b0;
         req_wr_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         req_wr_q <= req_wr_nxt;
         case (ex_sel)
            EX_LOAD_ID:  ex_sh <= id_sh;
            EX_LOAD_NOP: ex_sh <= '0;
            default:     ex_sh <= ex_sh;
         endcase
         if (wb_adv) begin
            wb_rd <= ex_sh.rd;
            wb_wr <= ex_sh.wr;
         end else begin
            wb_wr <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_wr_nxt = req_wr_q;
      ex_sel     = EX_HOLD;
      wb_adv     = 1'b0;
      PC_stall   = 1'b0;
      ID_stall   = 1'b0;
      EX_bubble  = 1'b0;
      EX_stall   = 1'b0;
      WB_bubble  = 1'b0;
      IF_flush   = 1'b0;
      dmem_req   = 1'b0;
      dmem_wr    = 1'b0;
      mem_err    = 1'b0;
      case (state)
         RUN: begin
            wb_adv = 1'b1;
            if (raw_hit) begin
               ex_sel    = EX_LOAD_NOP;
               PC_stall  = 1'b1;
               ID_stall  = 1'b1;
               EX_bubble = 1'b1;
            end else begin
               ex_sel   = EX_LOAD_ID;
               IF_flush = taken;
            end
            if (ex_sh.mem) begin
               dmem_req = 1'b1;
               dmem_wr  = ex_sh.memwr;
               // The request direction is latched so it stays stable while waiting.
               if (!dmem_ack) begin
                  state_nxt  = MEM_WAIT;
                  cnt_nxt    = CNT_W'(1);
                  req_wr_nxt = ex_sh.memwr;
               end
            end
         end
         MEM_WAIT: begin
            PC_stall  = 1'b1;
            ID_stall  = 1'b1;
            EX_stall  = 1'b1;
            WB_bubble = 1'b1;
            dmem_req  = 1'b1;
            dmem_wr   = req_wr_q;
            cnt_nxt   = cnt + CNT_W'(1);
            if (dmem_ack) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
               ex_sel    = EX_LOAD_ID;
               wb_adv    = 1'b1;
            end else if (timeout) begin
               mem_err   = 1'b1;
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of per-cycle vectors plus watchdog sequences.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 8;

   logic       clk, reset;
   logic [4:0] ID_rD, ID_rA, ID_rB;
   logic       ID_wrEn, ID_memEn, ID_memwrEn, ID_bez, ID_bnez, ID_rD_zero, dmem_ack;
   logic       PC_stall, ID_stall, EX_bubble, EX_stall, WB_bubble, IF_flush;
   logic       dmem_req, dmem_wr, mem_err;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ID_rD(ID_rD), .ID_rA(ID_rA), .ID_rB(ID_rB),
      .ID_wrEn(ID_wrEn), .ID_memEn(ID_memEn), .ID_memwrEn(ID_memwrEn),
      .ID_bez(ID_bez), .ID_bnez(ID_bnez), .ID_rD_zero(ID_rD_zero),
      .dmem_ack(dmem_ack),
      .PC_stall(PC_stall), .ID_stall(ID_stall), .EX_bubble(EX_bubble),
      .EX_stall(EX_stall), .WB_bubble(WB_bubble), .IF_flush(IF_flush),
      .dmem_req(dmem_req), .dmem_wr(dmem_wr), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector order: PC_stall ID_stall EX_bubble EX_stall WB_bubble IF_flush dmem_req dmem_wr mem_err
   localparam logic [8:0] O_NONE  = 9'b000_000_000;
   localparam logic [8:0] O_STALL = 9'b111_000_000;
   localparam logic [8:0] O_FLUSH = 9'b000_001_000;
   localparam logic [8:0] O_REQ   = 9'b000_000_100;
   localparam logic [8:0] O_WR    = 9'b000_000_010;
   localparam logic [8:0] O_ERR   = 9'b000_000_001;
   localparam logic [8:0] O_WAIT  = 9'b110_110_100;
`ifdef WB_BYPASS_EN
   localparam logic [8:0] O_WB_RAW = O_NONE;
   localparam logic [8:0] O_WB_BR  = O_FLUSH;
`else
   localparam logic [8:0] O_WB_RAW = O_STALL;
   localparam logic [8:0] O_WB_BR  = O_STALL;
`endif

   typedef struct packed {
      logic [4:0] rd, ra, rb;
      logic       wr, mem, memwr, bez, bnez, rdz;
   } ins_t;

   typedef struct {
      string      name;
      ins_t       ins;
      logic       ack;
      logic       rst;
      logic [8:0] exp;
   } vec_t;

   int         errors = 0;
   int         checks = 0;
   logic [8:0] exp_q[$];
   vec_t       tbl[$];

   function automatic ins_t nop();
      return '0;
   endfunction
   function automatic ins_t rtype(logic [4:0] rd, logic [4:0] ra, logic [4:0] rb);
      ins_t i = '0;
      i.rd = rd; i.ra = ra; i.rb = rb; i.wr = 1'b1;
      return i;
   endfunction
   function automatic ins_t vld(logic [4:0] rd, logic [4:0] ra);
      ins_t i = '0;
      i.rd = rd; i.ra = ra; i.mem = 1'b1;
      return i;
   endfunction
   function automatic ins_t vsd(logic [4:0] rd, logic [4:0] ra);
      ins_t i = '0;
      i.rd = rd; i.ra = ra; i.mem = 1'b1; i.memwr = 1'b1;
      return i;
   endfunction
   function automatic ins_t vbr(logic [4:0] rd, logic bnez, logic rdz);
      ins_t i = '0;
      i.rd = rd; i.bez = ~bnez; i.bnez = bnez; i.rdz = rdz;
      return i;
   endfunction
   function automatic vec_t mk(string n, ins_t i, logic ack, logic rst, logic [8:0] e);
      vec_t v;
      v.name = n; v.ins = i; v.ack = ack; v.rst = rst; v.exp = e;
      return v;
   endfunction

   task automatic drive(ins_t i, logic ack, logic rst);
      reset      = rst;
      dmem_ack   = ack;
      ID_rD      = i.rd;
      ID_rA      = i.ra;
      ID_rB      = i.rb;
      ID_wrEn    = i.wr;
      ID_memEn   = i.mem;
      ID_memwrEn = i.memwr;
      ID_bez     = i.bez;
      ID_bnez    = i.bnez;
      ID_rD_zero = i.rdz;
   endtask

   task automatic check(string name);
      logic [8:0] act, e;
      act = {PC_stall, ID_stall, EX_bubble, EX_stall, WB_bubble, IF_flush, dmem_req, dmem_wr, mem_err};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected entry queued, outputs=%b", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s: outputs=%b expected=%b", name, act, e);
         end
      end
   endtask

   task automatic step(string name, ins_t i, logic ack, logic rst, logic [8:0] e);
      @(posedge clk);
      #1;
      drive(i, ack, rst);
      exp_q.push_back(e);
      @(negedge clk);
      check(name);
   endtask

   task automatic timeout_seq(string tag, logic ack_last);
      step({tag, "_sd_id"}, vsd(5'd14, 5'd2), 1'b0, 1'b0, O_NONE);
      step({tag, "_req"}, nop(), 1'b0, 1'b0, O_REQ | O_WR);
      for (int n = 1; n <= MEM_TIMEOUT - 1; n++) begin
         logic last;
         last = (n == MEM_TIMEOUT - 1);
         step($sformatf("%s_wait%0d", tag, n), nop(), last & ack_last, 1'b0,
              O_WAIT | O_WR | ((last && !ack_last) ? O_ERR : O_NONE));
      end
      step({tag, "_after"}, nop(), 1'b0, 1'b0, O_NONE);
   endtask

   initial begin
      drive(nop(), 1'b0, 1'b1);
      repeat (2) @(posedge clk);

      tbl.push_back(mk("reset_idle",     nop(),                  0, 0, O_NONE));
      tbl.push_back(mk("rtype_w5",       rtype(5'd5, 5'd1, 5'd2), 0, 0, O_NONE));
      tbl.push_back(mk("raw_ex",         rtype(5'd6, 5'd5, 5'd3), 0, 0, O_STALL));
      tbl.push_back(mk("raw_wb",         rtype(5'd6, 5'd5, 5'd3), 0, 0, O_WB_RAW));
      tbl.push_back(mk("raw_issue",      rtype(5'd6, 5'd5, 5'd3), 0, 0, O_NONE));
      tbl.push_back(mk("nop_a",          nop(),                  0, 0, O_NONE));
      tbl.push_back(mk("nop_b",          nop(),                  0, 0, O_NONE));
      tbl.push_back(mk("bez_taken",      vbr(5'd7, 0, 1),        0, 0, O_FLUSH));
      tbl.push_back(mk("bez_not_taken",  vbr(5'd7, 0, 0),        0, 0, O_NONE));
      tbl.push_back(mk("bnez_taken",     vbr(5'd7, 1, 0),        0, 0, O_FLUSH));
      tbl.push_back(mk("rtype_w9",       rtype(5'd9, 5'd0, 5'd0), 0, 0, O_NONE));
      tbl.push_back(mk("bez_stall_ex",   vbr(5'd9, 0, 1),        0, 0, O_STALL));
      tbl.push_back(mk("bez_stall_wb",   vbr(5'd9, 0, 1),        0, 0, O_WB_BR));
      tbl.push_back(mk("bez_reeval",     vbr(5'd9, 0, 1),        0, 0, O_FLUSH));
      tbl.push_back(mk("nop_c",          nop(),                  0, 0, O_NONE));
      tbl.push_back(mk("ld_id",          vld(5'd10, 5'd1),       0, 0, O_NONE));
      tbl.push_back(mk("ld_ack_same",    nop(),                  1, 0, O_REQ));
      tbl.push_back(mk("ld_done",        nop(),                  0, 0, O_NONE));
      tbl.push_back(mk("sd_id",          vsd(5'd11, 5'd2),       0, 0, O_NONE));
      tbl.push_back(mk("sd_req",         nop(),                  0, 0, O_REQ | O_WR));
      tbl.push_back(mk("sd_wait1",       nop(),                  0, 0, O_WAIT | O_WR));
      tbl.push_back(mk("sd_wait2",       nop(),                  0, 0, O_WAIT | O_WR));
      tbl.push_back(mk("sd_wait3_ack",   nop(),                  1, 0, O_WAIT | O_WR));
      tbl.push_back(mk("sd_done",        nop(),                  0, 0, O_NONE));
      tbl.push_back(mk("ld2_id",         vld(5'd12, 5'd3),       0, 0, O_NONE));
      tbl.push_back(mk("ld2_req",        rtype(5'd13, 5'd4, 5'd4), 0, 0, O_REQ));
      tbl.push_back(mk("ld2_wait_rst",   nop(),                  0, 1, O_WAIT));
      tbl.push_back(mk("post_rst_clean", rtype(5'd1, 5'd13, 5'd12), 0, 0, O_NONE));
      tbl.push_back(mk("post_rst_nop",   nop(),                  0, 0, O_NONE));

      for (int k = 0; k < tbl.size(); k++)
         step(tbl[k].name, tbl[k].ins, tbl[k].ack, tbl[k].rst, tbl[k].exp);

      timeout_seq("to_noack", 1'b0);
      timeout_seq("to_ack", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 4-stage vector core: IF, ID, EXMEM, WB.
- Consumes the ID-stage control fields from the instruction decoder.
- Keeps its own shadow of the EXMEM and WB destination registers.
- Generates stall, bubble and flush controls for the pipeline registers.
- Owns the data-memory request/acknowledge handshake, including a watchdog timeout.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM_WAIT before the access is abandoned; legal range 2..255.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ID_rD  input  5  ID destination / store-data / branch-test register
ID_rA  input  5  ID source A
ID_rB  input  5  ID source B
ID_wrEn  input  1  ID instruction writes the register file (R-type)
ID_memEn  input  1  ID instruction accesses data memory
ID_memwrEn  input  1  ID memory access is a store
ID_bez  input  1  ID is a taken-if-zero branch
ID_bnez  input  1  ID is a taken-if-nonzero branch
ID_rD_zero  input  1  register-file value of ID_rD is all zeros
dmem_ack  input  1  data memory completes the current request
PC_stall  output  1  hold PC
ID_stall  output  1  hold the IF/ID register
EX_bubble  output  1  load a NOP into ID/EX
EX_stall  output  1  hold ID/EX
WB_bubble  output  1  load a NOP into EX/WB
IF_flush  output  1  replace the IF/ID contents with a NOP
dmem_req  output  1  memory request valid
dmem_wr  output  1  request is a store
mem_err  output  1  one-cycle pulse on timeout

Behaviour:
Reset:
- state = RUN; counter = 0.
- All shadow valid, write and memory bits = 0.
- All outputs = 0 in the cycle after reset is sampled high.
- Reset mid-MEM_WAIT abandons the request; dmem_req drops the next cycle.

Writer and reader classification:
- ID is a writer if ID_wrEn, or if (ID_memEn & !ID_memwrEn) (a load).
- ID reads rA and rB when ID_wrEn.
- ID reads rD when it is a store, bez or bnez.
- All 32 registers participate in hazard checks; r0 is not special-cased.

Shadow pipeline, updated each edge unless the state is MEM_WAIT:
- The EX shadow takes the ID fields when there is no RAW stall; otherwise it takes a bubble (wr = 0, mem = 0).
- The WB shadow takes the EX shadow.
- In MEM_WAIT the EX shadow holds and the WB shadow takes a bubble.

RAW stall (combinational, state RUN):
- Condition: an ID source equals ex_rD with ex_wr, or equals wb_rD with wb_wr.
- On a stall: PC_stall = ID_stall = EX_bubble = 1.

Branch (state RUN, no RAW stall):
- taken = (ID_bez & ID_rD_zero) | (ID_bnez & !ID_rD_zero).
- IF_flush = taken for exactly one cycle.
- A stalled branch does not flush; it is re-evaluated on the following cycle.

RUN state:
- If ex_mem = 1: dmem_req = 1 and dmem_wr = ex_memwr, combinationally in the same cycle.
- dmem_ack in the same cycle completes the access with zero stall.
- Otherwise the next state is MEM_WAIT, with counter = 1.

MEM_WAIT state:
- dmem_req and dmem_wr held stable.
- PC_stall = ID_stall = EX_stall = WB_bubble = 1; EX_bubble = 0; IF_flush = 0.
- RAW and branch evaluation suppressed.
- counter increments each cycle.
- dmem_ack: go to RUN; EX advances on this edge.
- counter == MEM_TIMEOUT-1 without ack: mem_err pulses, the access is dropped, go to RUN.
- If ack and timeout occur in the same cycle, ack wins and there is no mem_err.

Priority: MEM_WAIT > RAW stall > flush.

Optional Feature:
WB_BYPASS_EN
- Defined: the register file writes through, so WB-shadow matches never stall; only EX-shadow matches stall.
- Undefined: both the EX and WB shadows are checked as described above.

Decomposition:
- Shared package ctrl_pkg holds:
  - instruction-type constants (RTYPE 6'b101010, VLD 6'b100000, VSD 6'b100001, VBEZ 6'b100010, VBNEZ 6'b100011, VNOP 6'b111100);
  - state encoding RUN = 1'b0, MEM_WAIT = 1'b1;
  - REG_ADDR_W = 5.
- One sub-module, raw_detect: a purely combinational comparison of the ID sources against one shadow entry. It is instantiated twice, and the WB instance is ignored under WB_BYPASS_EN.

Test Plan:
- R-type writing r5, then R-type with rA = 5 the next cycle -> PC_stall/ID_stall/EX_bubble = 1 for 2 cycles (1 with WB_BYPASS_EN), then the instruction issues.
- VBEZ with ID_rD_zero = 1 and no hazard -> IF_flush = 1 for exactly 1 cycle; the same branch with ID_rD_zero = 0 -> IF_flush = 0.
- VLD in EX, dmem_ack high in the same cycle -> dmem_req for 1 cycle, no stall, dmem_wr = 0.
- VSD in EX, dmem_ack after 3 cycles -> MEM_WAIT for 3 cycles, dmem_wr = 1 steady, EX_stall/WB_bubble = 1, then RUN.
- No ack with MEM_TIMEOUT = 16 -> mem_err pulses on wait cycle 15, then RUN and dmem_req = 0; ack asserted on that same cycle -> no mem_err.
- Reset asserted during MEM_WAIT -> next cycle all outputs 0, state RUN, and no hazards from prior shadow contents.
